// File: rtl/mdu.sv
// Multiply/divide unit holding the HI/LO pair for the E stage.
// Fixed-latency mult (5 cycles) and div (10 cycles); mthi/mtlo write at the accepting edge.
module mdu (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
   localparam logic [2:0] OP_RSVD  = 3'd7;

   localparam logic [3:0] MULT_CYCLES = 4'd5;
   localparam logic [3:0] DIV_CYCLES  = 4'd10;

   logic [0:0]  state_reg;
   logic [3:0]  cnt_reg;
   logic [2:0]  op_reg;
   logic [31:0] a_reg;
   logic [31:0] b_reg;
   logic [31:0] hi_reg;
   logic [31:0] lo_reg;

   logic        op_valid;
   logic        accept;
   logic        done;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        is_signed_div;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] quot_mag;
   logic [31:0] rem_mag;
   logic [31:0] res_hi_next;
   logic [31:0] res_lo_next;
   logic        res_we_next;

   assign op_valid = (op != OP_NONE) && (op != OP_RSVD);
   assign accept   = (state_reg == ST_IDLE) && start && op_valid;
   assign done     = (state_reg == ST_RUN) && (cnt_reg == 4'd1);

   assign busy  = (state_reg == ST_RUN);
   assign stall = busy | (start & op_valid);
   assign hi    = hi_reg;
   assign lo    = lo_reg;

   // Results are formed from the latched operands and only committed at the completion edge.
   always_comb begin
      prod_s        = $signed({{32{a_reg[31]}}, a_reg}) * $signed({{32{b_reg[31]}}, b_reg});
      prod_u        = {32'd0, a_reg} * {32'd0, b_reg};
      is_signed_div = (op_reg == OP_DIV);
      a_neg         = is_signed_div & a_reg[31];
      b_neg         = is_signed_div & b_reg[31];
      a_mag         = a_neg ? (32'd0 - a_reg) : a_reg;
      b_mag         = b_neg ? (32'd0 - b_reg) : b_reg;
      quot_mag      = 32'd0;
      rem_mag       = 32'd0;
      if (b_mag != 32'd0) begin
         quot_mag = a_mag / b_mag;
         rem_mag  = a_mag % b_mag;
      end

      res_hi_next = hi_reg;
      res_lo_next = lo_reg;
      res_we_next = 1'b0;
      case (op_reg)
         OP_MULT: begin
            res_hi_next = prod_s[63:32];
            res_lo_next = prod_s[31:0];
            res_we_next = 1'b1;
         end
         OP_MULTU: begin
            res_hi_next = prod_u[63:32];
            res_lo_next = prod_u[31:0];
            res_we_next = 1'b1;
         end
         OP_DIV, OP_DIVU: begin
            // Quotient truncates toward zero; remainder follows the dividend's sign.
            res_lo_next = (a_neg ^ b_neg) ? (32'd0 - quot_mag) : quot_mag;
            res_hi_next = a_neg ? (32'd0 - rem_mag) : rem_mag;
            res_we_next = (b_reg != 32'd0);
         end
         default: begin
            res_we_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 4'd0;
         op_reg    <= OP_NONE;
         a_reg     <= 32'd0;
         b_reg     <= 32'd0;
         hi_reg    <= 32'd0;
         lo_reg    <= 32'd0;
      end else if (accept) begin
         case (op)
            OP_MULT, OP_MULTU: begin
               state_reg <= ST_RUN;
               cnt_reg   <= MULT_CYCLES;
               op_reg    <= op;
               a_reg     <= rs;
               b_reg     <= rt;
            end
            OP_DIV, OP_DIVU: begin
               state_reg <= ST_RUN;
               cnt_reg   <= DIV_CYCLES;
               op_reg    <= op;
               a_reg     <= rs;
               b_reg     <= rt;
            end
            OP_MTHI: hi_reg <= rs;
            OP_MTLO: lo_reg <= rs;
            default: ;
         endcase
      end else if (state_reg == ST_RUN) begin
         cnt_reg <= cnt_reg - 4'd1;
         if (done) begin
            state_reg <= ST_IDLE;
            if (res_we_next) begin
               hi_reg <= res_hi_next;
               lo_reg <= res_lo_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for the mdu: latency, results, reset abort and back-to-back issue.
module tb_mdu;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks;
   int failures;

   mdu dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .rs    (rs),
      .rt    (rt),
      .busy  (busy),
      .stall (stall),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op for a single edge, then count edges until busy falls (bounded).
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output bit held);
      logic [31:0] h0;
      logic [31:0] l0;
      start = 1'b1;
      op    = o;
      rs    = a;
      rt    = b;
      tick();
      start = 1'b0;
      op    = 3'd0;
      h0    = hi;
      l0    = lo;
      held  = 1'b1;
      cycles = 0;
      while (busy && cycles < 30) begin
         if (hi !== h0 || lo !== l0) held = 1'b0;
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      op    = 3'd0;
      rs    = 32'd0;
      rt    = 32'd0;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0) begin
         failures++;
         $display("FAIL reset_state busy=%b stall=%b hi=%h lo=%h required 0 0 0 0", busy, stall, hi, lo);
      end
      reset = 1'b1;
      tick();
      $display("reset: busy=%b hi=%h lo=%h", busy, hi, lo);
   endtask

   task automatic test_mult();
      int  cyc;
      bit  held;
      start = 1'b1; op = 3'd1; rs = 32'hFFFFFFFE; rt = 32'd3;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("FAIL mult_stall_comb stall=%b required 1", stall);
      end
      run_op(3'd1, 32'hFFFFFFFE, 32'd3, cyc, held);
      $display("mult: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
      checks++;
      if (cyc != 5) begin
         failures++;
         $display("FAIL mult_latency got=%0d required=5", cyc);
      end
      checks++;
      if (!held) begin
         failures++;
         $display("FAIL mult_hold hi/lo changed during RUN");
      end
      checks++;
      if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
         failures++;
         $display("FAIL mult_result hi=%h lo=%h required FFFFFFFF FFFFFFFA", hi, lo);
      end
   endtask

   task automatic test_multu();
      int cyc;
      bit held;
      run_op(3'd2, 32'hFFFFFFFE, 32'd3, cyc, held);
      $display("multu: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
      checks++;
      if (cyc != 5 || hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
         failures++;
         $display("FAIL multu cycles=%0d hi=%h lo=%h required 5 00000002 FFFFFFFA", cyc, hi, lo);
      end
   endtask

   task automatic test_div();
      int cyc;
      bit held;
      run_op(3'd3, 32'hFFFFFFF9, 32'd2, cyc, held);
      $display("div -7/2: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
      checks++;
      if (cyc != 10) begin
         failures++;
         $display("FAIL div_latency got=%0d required=10", cyc);
      end
      checks++;
      if (!held) begin
         failures++;
         $display("FAIL div_hold hi/lo changed during RUN");
      end
      checks++;
      if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
         failures++;
         $display("FAIL div_neg_dividend hi=%h lo=%h required FFFFFFFF FFFFFFFD", hi, lo);
      end
      run_op(3'd3, 32'd7, 32'hFFFFFFFE, cyc, held);
      $display("div 7/-2: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
      checks++;
      if (hi !== 32'd1 || lo !== 32'hFFFFFFFD) begin
         failures++;
         $display("FAIL div_neg_divisor hi=%h lo=%h required 00000001 FFFFFFFD", hi, lo);
      end
      run_op(3'd4, 32'hFFFFFFFF, 32'h10, cyc, held);
      $display("divu: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
      checks++;
      if (cyc != 10 || hi !== 32'h0000000F || lo !== 32'h0FFFFFFF) begin
         failures++;
         $display("FAIL divu cycles=%0d hi=%h lo=%h required 10 0000000F 0FFFFFFF", cyc, hi, lo);
      end
   endtask

   task automatic test_div_zero();
      int cyc;
      bit held;
      run_op(3'd4, 32'd1234, 32'd0, cyc, held);
      $display("divu by zero: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
      checks++;
      if (cyc != 10 || hi !== 32'h0000000F || lo !== 32'h0FFFFFFF) begin
         failures++;
         $display("FAIL divu_zero cycles=%0d hi=%h lo=%h required 10 0000000F 0FFFFFFF", cyc, hi, lo);
      end
      run_op(3'd3, 32'hFFFFFF00, 32'd0, cyc, held);
      $display("div by zero: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
      checks++;
      if (cyc != 10 || hi !== 32'h0000000F || lo !== 32'h0FFFFFFF) begin
         failures++;
         $display("FAIL div_zero cycles=%0d hi=%h lo=%h required 10 0000000F 0FFFFFFF", cyc, hi, lo);
      end
   endtask

   task automatic test_div_overflow();
      int cyc;
      bit held;
      run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, cyc, held);
      $display("div overflow: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
      checks++;
      if (cyc != 10 || hi !== 32'h00000000 || lo !== 32'h80000000) begin
         failures++;
         $display("FAIL div_overflow cycles=%0d hi=%h lo=%h required 10 00000000 80000000", cyc, hi, lo);
      end
   endtask

   task automatic test_mthi_mtlo();
      int cyc;
      bit held;
      run_op(3'd5, 32'h12345678, 32'd0, cyc, held);
      $display("mthi: cycles=%0d busy=%b hi=%h lo=%h", cyc, busy, hi, lo);
      checks++;
      if (cyc != 0 || busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'h80000000) begin
         failures++;
         $display("FAIL mthi cycles=%0d busy=%b hi=%h lo=%h required 0 0 12345678 80000000", cyc, busy, hi, lo);
      end
      run_op(3'd6, 32'hCAFEF00D, 32'd0, cyc, held);
      $display("mtlo: cycles=%0d busy=%b hi=%h lo=%h", cyc, busy, hi, lo);
      checks++;
      if (cyc != 0 || busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL mtlo cycles=%0d busy=%b hi=%h lo=%h required 0 0 12345678 CAFEF00D", cyc, busy, hi, lo);
      end
   endtask

   task automatic test_reserved_ops();
      start = 1'b1; op = 3'd7; rs = 32'hDEADBEEF; rt = 32'd1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL op7_stall stall=%b required 0", stall);
      end
      tick();
      op = 3'd0;
      tick();
      start = 1'b0;
      $display("op7/op0: busy=%b hi=%h lo=%h", busy, hi, lo);
      checks++;
      if (busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL reserved_ops busy=%b hi=%h lo=%h required 0 12345678 CAFEF00D", busy, hi, lo);
      end
   endtask

   task automatic test_ignore_in_run();
      int cyc;
      start = 1'b1; op = 3'd3; rs = 32'd100; rt = 32'd7;
      tick();
      start = 1'b0; op = 3'd0;
      cyc = 0;
      while (busy && cyc < 30) begin
         if (cyc == 2) begin
            start = 1'b1; op = 3'd1; rs = 32'd1000; rt = 32'd1000;
         end else begin
            start = 1'b0; op = 3'd0;
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      $display("div with mult during RUN: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
      checks++;
      if (cyc != 10 || hi !== 32'd2 || lo !== 32'd14) begin
         failures++;
         $display("FAIL ignore_in_run cycles=%0d hi=%h lo=%h required 10 00000002 0000000E", cyc, hi, lo);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL ignore_in_run_idle busy=%b required 0", busy);
      end
   endtask

   task automatic test_reset_mid_run();
      start = 1'b1; op = 3'd1; rs = 32'hFFFFFFFE; rt = 32'd3;
      tick();
      start = 1'b0; op = 3'd0;
      tick(); tick(); tick();
      reset = 1'b0;
      #2;
      $display("reset mid-run: busy=%b stall=%b hi=%h lo=%h", busy, stall, hi, lo);
      checks++;
      if (busy !== 1'b0 || stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_async busy=%b stall=%b hi=%h lo=%h required 0 0 0 0", busy, stall, hi, lo);
      end
      tick(); tick();
      reset = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      $display("after release: busy=%b hi=%h lo=%h", busy, hi, lo);
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_no_completion busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      start = 1'b1; op = 3'd1; rs = 32'd3; rt = 32'd4;
      tick();
      start = 1'b0; op = 3'd0;
      tick(); tick(); tick(); tick();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_busy_before busy=%b required 1", busy);
      end
      start = 1'b1; op = 3'd1; rs = 32'd5; rt = 32'd6;
      tick();
      $display("b2b completion edge: busy=%b stall=%b hi=%h lo=%h", busy, stall, hi, lo);
      checks++;
      if (busy !== 1'b0 || stall !== 1'b1 || hi !== 32'd0 || lo !== 32'd12) begin
         failures++;
         $display("FAIL b2b_reject busy=%b stall=%b hi=%h lo=%h required 0 1 0 0000000C", busy, stall, hi, lo);
      end
      tick();
      start = 1'b0; op = 3'd0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_accept busy=%b required 1", busy);
      end
      cyc = 0;
      while (busy && cyc < 30) begin
         tick();
         cyc++;
      end
      $display("b2b second mult: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
      checks++;
      if (cyc != 5 || hi !== 32'd0 || lo !== 32'd30) begin
         failures++;
         $display("FAIL b2b_result cycles=%0d hi=%h lo=%h required 5 0 0000001E", cyc, hi, lo);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_div_zero();
      test_div_overflow();
      test_mthi_mtlo();
      test_reserved_ops();
      test_ignore_in_run();
      test_reset_mid_run();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 clk  input  1  Rising-edge clock; all state changes on the rising edge.
REQ-002 reset  input  1  Asynchronous, active-low reset; reset=0 forces reset state immediately, independent of clk.
REQ-003 start  input  1  E-stage qualifier; op, rs and rt are sampled at the edge where start=1 is accepted.
REQ-004 op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
REQ-005 rs  input  32  Operand A, from the E-stage forwarded RD1 value.
REQ-006 rt  input  32  Operand B, from the E-stage forwarded RD2 value.
REQ-007 busy  output  1  High while a mult/div is in flight.
REQ-008 stall  output  1  Combinational; busy OR (start AND op in 1..6); drives the hazard unit to freeze F/D and bubble E.
REQ-009 hi  output  32  Registered HI value.
REQ-010 lo  output  32  Registered LO value.

Function
REQ-011 Two states: IDLE (busy=0) and RUN (busy=1); a 4-bit down-counter cnt tracks cycles remaining in RUN.
REQ-012 Acceptance: a start is accepted only in IDLE with op in 1..6; start while in RUN, op=0 or op=7 has no effect on any state.
REQ-013 Accepted mult/multu at edge k: latch operands and load cnt=5; busy=1 after edge k.
REQ-014 Accepted div/divu at edge k: latch operands and load cnt=10; busy=1 after edge k.
REQ-015 RUN: cnt decrements each edge; at the edge where cnt goes 1->0, write hi/lo and return to IDLE; busy=0 after that edge.
REQ-016 Latency: mult gives busy high for exactly 5 cycles and new hi/lo visible after edge k+5; div gives 10 cycles and new hi/lo after edge k+10.
REQ-017 hi and lo hold their prior values throughout RUN and change only at the completion edge.
REQ-018 mult: signed 32x32 -> 64-bit product; hi=[63:32], lo=[31:0].
REQ-019 multu: same as mult with operands treated as unsigned.
REQ-020 div: signed division; lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend (rs).
REQ-021 divu: unsigned division; lo = quotient; hi = remainder.
REQ-022 Divisor zero (div or divu): runs the full 10 cycles; hi and lo are left unchanged at completion.
REQ-023 div with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000, with no other effect.
REQ-024 mthi and mtlo: take effect at the accepting edge (hi<=rs or lo<=rs); no RUN state and no busy.
REQ-025 Result computation is free to be combinational at acceptance with a pending register, or iterative; only the cycle-level visibility defined in REQ-015 to REQ-017 is normative.
REQ-026 A new start presented in the same cycle busy falls is rejected, since the state is still RUN at that edge; it is accepted on the next edge.

Reset
REQ-027 While reset=0: busy=0, state=IDLE, cnt=0, hi=0, lo=0, and any pending result is discarded.
REQ-028 Reset asserted mid-RUN aborts the operation; after release, no completion write occurs.
REQ-029 stall=0 while reset=0 and start=0.

Verification
REQ-030 mult rs=0xFFFFFFFE, rt=0x00000003 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA after 5 cycles.
REQ-032 div rs=0xFFFFFFF9 (-7), rt=2 -> busy high for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu rt=0 -> hi/lo unchanged.
REQ-033 mthi rs=0x12345678 -> hi=0x12345678 after one edge with busy=0; a second start (mult) issued during a div RUN is ignored and hi/lo reflect only the div.
REQ-034 reset pulsed low 3 cycles into a mult -> hi=lo=0 and busy=0 immediately; after release, hi/lo stay 0.
REQ-035 Back-to-back: start held with mult at the edge busy falls -> that edge does not accept; acceptance occurs on the next edge and the result appears 5 edges after acceptance.
